// File: rtl/fifo_reader_pkg.sv
// Shared constants and FSM encoding for the FIFO burst reader.
package fifo_reader_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// Upstream FIFO pop port plus downstream valid/ready stream.
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rdata;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry output buffer: head drives the stream, tail absorbs one extra word.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             head_v;
    logic             tail_v;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             pop_c;

    assign pop_c = head_v & out_ready;

    // Capture/pop bookkeeping; entries always fill head first, tail shifts to head on pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({tail_v, head_v})
                2'b00: begin
                    if (in_valid) begin
                        head_v <= 1'b1;
                        head_q <= in_data;
                    end
                end
                2'b01: begin
                    if (in_valid && pop_c) begin
                        head_q <= in_data;
                    end else if (in_valid) begin
                        tail_v <= 1'b1;
                        tail_q <= in_data;
                    end else if (pop_c) begin
                        head_v <= 1'b0;
                    end
                end
                2'b11: begin
                    if (pop_c) begin
                        head_q <= tail_q;
                        if (in_valid) begin
                            tail_q <= in_data;
                        end else begin
                            tail_v <= 1'b0;
                        end
                    end
                end
                default: begin
                    head_v <= 1'b0;
                    tail_v <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = head_v;
    assign out_data  = head_q;
    assign occupancy = OCC_W'(head_v) + OCC_W'(tail_v);

endmodule

// File: rtl/fifo_reader.sv
// Reads a burst of words from an upstream FIFO and streams them downstream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    fifo_reader_if.master    bus
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inflight_q;
    logic             done_d;
    logic             busy_q;
    logic             done_q;

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [OCC_W-1:0] occ;
    logic             pop_c;
    logic [2:0]       occ_after_c;
    logic             rd_en_c;

    fifo_reader_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   (bus.fifo_rdata),
        .out_ready (bus.m_ready),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .occupancy (occ)
    );

    // Buffer fill level once this cycle's capture and pop have settled.
    assign pop_c       = skid_valid & bus.m_ready;
    assign occ_after_c = 3'(occ) + 3'(inflight_q) - 3'(pop_c);
    assign rd_en_c     = (state_q == ST_RUN) && !bus.fifo_empty &&
                         (cnt_q != '0) && (occ_after_c < 3'd2);

    assign bus.fifo_rd_en = rd_en_c;
    assign bus.m_valid    = skid_valid;
    assign bus.m_data     = skid_data;
    assign busy           = busy_q;
    assign done           = done_q;

    // Next-state, issue counter and completion pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = burst_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (rd_en_c) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once the last in-flight word has been captured and popped.
                if (occ_after_c == 3'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= rd_en_c;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
        end
    end

endmodule
